// File: rtl/add_unit.sv
// add_unit: saturating unsigned adder for path-metric update.
//
// Adds an unsigned branch metric to an unsigned path metric and clamps the
// result to all-ones when the true sum does not fit in W bits. The result is
// registered with a single cycle of latency and accepted every cycle.
//
// Ports
//   i_clk    : clock, all state updates on the rising edge
//   i_rst_n  : synchronous active-low reset, overrides i_valid
//   i_valid  : i_BM/i_PM carry a valid operand pair this cycle
//   i_BM     : branch metric, unsigned, W bits
//   i_PM     : path metric, unsigned, W bits
//   o_valid  : i_valid delayed by one cycle
//   o_PM     : saturated sum, held while no new valid pair arrives
//   o_sat    : result was clamped (true sum strictly above 2^W-1)
module add_unit #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_BM,
  input  logic [W-1:0] i_PM,
  output logic         o_valid,
  output logic [W-1:0] o_PM,
  output logic         o_sat
);

  // Largest representable result, widened to the sum width for comparison.
  localparam logic [W:0] SUM_MAX = {1'b0, {W{1'b1}}};

  // A sum of exactly 2^W-1 fits, so it is passed through and not flagged.
  function automatic logic is_over(input logic [W:0] s);
    return (s > SUM_MAX);
  endfunction

  function automatic logic [W-1:0] sat_clamp(input logic [W:0] s);
    return is_over(s) ? {W{1'b1}} : s[W-1:0];
  endfunction

  logic [W:0]   sum_p0;
  logic         vld_p1;
  logic [W-1:0] pm_p1;
  logic         sat_p1;

  // Stage p0: full-precision sum, one extra bit so no carry is lost.
  assign sum_p0 = {1'b0, i_BM} + {1'b0, i_PM};

  // Stage p1: output registers; data only loads on a valid pair.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      pm_p1  <= '0;
      sat_p1 <= 1'b0;
    end else begin
      vld_p1 <= i_valid;
      if (i_valid) begin
        pm_p1  <= sat_clamp(sum_p0);
        sat_p1 <= is_over(sum_p0);
      end
    end
  end

  assign o_valid = vld_p1;
  assign o_PM    = pm_p1;
  assign o_sat   = sat_p1;

endmodule

// File: tb/tb_add_unit.sv
module tb_add_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vld;
  logic [1:0] bm2, pm2;
  logic [3:0] bm4, pm4;

  logic       o_vld2, o_sat2;
  logic [1:0] o_pm2;
  logic       o_vld4, o_sat4;
  logic [3:0] o_pm4;

  add_unit #(.W(2)) u_w2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_BM(bm2), .i_PM(pm2),
    .o_valid(o_vld2), .o_PM(o_pm2), .o_sat(o_sat2)
  );

  add_unit #(.W(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_BM(bm4), .i_PM(pm4),
    .o_valid(o_vld4), .o_PM(o_pm4), .o_sat(o_sat4)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] pm;
    logic       sat;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];

  int checks = 0;
  int passes = 0;
  bit done   = 1'b0;

  // Reference model: observable output state per width.
  int held_pm2 = 0, held_sat2 = 0;
  int held_pm4 = 0, held_sat4 = 0;

  function automatic exp_t model(input int rst_n_i, input int v, input int a, input int b,
                                 input int maxv, inout int held_pm, inout int held_sat);
    exp_t e;
    int s;
    s = a + b;
    if (rst_n_i == 0) begin
      held_pm = 0; held_sat = 0; e.v = 1'b0;
    end else if (v != 0) begin
      held_pm  = (s > maxv) ? maxv : s;
      held_sat = (s > maxv) ? 1 : 0;
      e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.pm  = 4'(held_pm);
    e.sat = held_sat[0];
    return e;
  endfunction

  // Present inputs, let one rising edge consume them, record expectation.
  task automatic step(input logic r, input logic v, input int a2, input int b2,
                      input int a4, input int b4);
    rst_n = r; vld = v;
    bm2 = 2'(a2); pm2 = 2'(b2); bm4 = 4'(a4); pm4 = 4'(b4);
    @(posedge clk);
    q2.push_back(model(int'(r), int'(v), a2, b2, 3, held_pm2, held_sat2));
    q4.push_back(model(int'(r), int'(v), a4, b4, 15, held_pm4, held_sat4));
    #1;
  endtask

  // Monitor: one expectation per edge per instance, compared away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      checks++;
      if ({o_vld2, 2'b00, o_pm2, o_sat2} === {e.v, e.pm, e.sat}) passes++;
      else $display("FAIL w2_out: got vld=%b pm=%0d sat=%b, expected vld=%b pm=%0d sat=%b",
                    o_vld2, o_pm2, o_sat2, e.v, e.pm, e.sat);
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks++;
      if ({o_vld4, o_pm4, o_sat4} === {e.v, e.pm, e.sat}) passes++;
      else $display("FAIL w4_out: got vld=%b pm=%0d sat=%b, expected vld=%b pm=%0d sat=%b",
                    o_vld4, o_pm4, o_sat4, e.v, e.pm, e.sat);
    end
  end

  initial begin
    int a, b, c, d;
    rst_n = 1'b0; vld = 1'b0; bm2 = '0; pm2 = '0; bm4 = '0; pm4 = '0;

    // Reset with valid operands present: they must be discarded.
    step(1'b0, 1'b1, 3, 3, 15, 15);
    step(1'b0, 1'b1, 2, 3, 9, 9);
    step(1'b1, 1'b0, 0, 0, 0, 0);

    // Exhaustive W=2 back-to-back; W=4 sees the same small values.
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, i / 4, i % 4, i / 4, i % 4);

    // Boundary pairs, then W=4 sweep pairs.
    step(1'b1, 1'b1, 1, 2, 7, 8);
    step(1'b1, 1'b1, 2, 2, 9, 9);
    step(1'b1, 1'b1, 3, 0, 15, 0);
    step(1'b1, 1'b1, 2, 1, 8, 7);

    // Hold: a result followed by three idle cycles with saturating operands.
    step(1'b1, 1'b1, 1, 1, 5, 5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3, 3, 15, 15);

    // Reset mid-stream, then first pair after release.
    step(1'b1, 1'b1, 2, 1, 10, 1);
    step(1'b0, 1'b1, 3, 3, 15, 15);
    step(1'b1, 1'b1, 0, 1, 0, 1);
    step(1'b1, 1'b0, 0, 0, 0, 0);

    // Random pairs, each immediately followed by its swapped twin.
    for (int i = 0; i < 600; i++) begin
      a = int'($urandom_range(0, 3));  b = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 15)); d = int'($urandom_range(0, 15));
      step(1'b1, 1'b1, a, b, c, d);
      step(1'b1, 1'b1, b, a, d, c);
      if ($urandom_range(0, 9) == 0) step(1'b1, 1'b0, b, b, c, c);
    end

    step(1'b1, 1'b0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && (q2.size() + q4.size()) > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q2.size() == 0 && q4.size() == 0) passes++;
    else $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q2.size(), q4.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
